histo_th_calc: RTL
==================

Name: histo_th_calc

Overview:
- Reader side of the histogram SRAM. Once the histogram builder has filled the 256-bin histogram SRAM, this block streams it out bin by bin.
- It accumulates a cumulative pixel count and derives the P_TH_NUM quantization thresholds at the equal-population points k*N/2^P_DEPTH_QNT_BIT.
- It feeds those thresholds to the pixel quantizer, which maps 8-bit pixels to 3-bit codes.

Parameters:
- P_DEPTH_BIT, 8, input pixel width; histogram has 2**P_DEPTH_BIT bins.
- P_DEPTH_SIZE_BIT, 10, histogram bin value width (histo SRAM data width).
- P_DEPTH_QNT_BIT, 3, quantized pixel width.
- P_TH_NUM, 7, number of thresholds, equal to 2**P_DEPTH_QNT_BIT-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; begins a calculation when idle
- pix_num_i  in  P_DEPTH_SIZE_BIT+1  total pixel count N; sampled with start_i
- busy_o  out  1  calculation in progress
- histo_rd_en_o  out  1  histo SRAM read enable
- histo_rd_addr_o  out  P_DEPTH_BIT  histo SRAM read address
- histo_rd_data_i  in  P_DEPTH_SIZE_BIT  histo SRAM read data, valid 1 cycle after rd_en
- histo_wr_en_o  out  1  histo SRAM write enable (clear-on-read feature)
- histo_wr_addr_o  out  P_DEPTH_BIT  histo SRAM write address
- histo_wr_data_o  out  P_DEPTH_SIZE_BIT  histo SRAM write data, always 0
- th_o  out  P_TH_NUM*P_DEPTH_BIT  packed thresholds; th k-1 sits at bits [k*P_DEPTH_BIT-1 -: P_DEPTH_BIT]
- th_vld_o  out  1  one-cycle pulse; th_o updated this cycle

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal cumsum, counters and working thresholds 0.
- FSM states:
  - IDLE: start_i=1 latches pix_num_i, clears cumsum, loads all working thresholds with 2**P_DEPTH_BIT-1 and all "found" flags with 0, then goes to READ.
  - READ: histo_rd_en_o=1, addr counts 0..2**P_DEPTH_BIT-1 one per cycle. After issuing the last address, go to DRAIN.
  - DRAIN: one cycle to accept the last read data, then go to DONE.
  - DONE: copy working thresholds to th_o, pulse th_vld_o for one cycle, return to IDLE.
- busy_o is high in READ, DRAIN and DONE.
- Timing, with start_i seen on edge 0:
  - rd addresses 0..255 are issued in cycles 1..256.
  - Data for addr a arrives in cycle a+2.
  - th_vld_o is high in cycle 258.
  - Total latency is 258 cycles, start pulse to valid.
- Accumulation on each returned bin b: cumsum <= cumsum + data, computed as P_DEPTH_SIZE_BIT+2 bits with no wrap.
- Targets: target_k = (k*N) >> P_DEPTH_QNT_BIT for k=1..P_TH_NUM, computed combinationally from the latched N.
- Threshold capture: for each k with found_k=0 and new cumsum >= target_k, th_k <= b and found_k <= 1.
  - Several thresholds may resolve on the same bin.
  - Thresholds are non-decreasing by construction.
- Threshold never reached (histogram sum < target) keeps the preset value 2**P_DEPTH_BIT-1.
- N=0: all targets are 0, so every threshold resolves at bin 0.
- start_i while busy is ignored: no restart, pix_num_i is not resampled.
- th_o holds its last value between calculations and changes only in the th_vld_o cycle.
- Asynchronous reset mid-operation returns to IDLE with all outputs 0. No th_vld_o is issued for the aborted run.

Optional Feature:
- Macro: HISTO_CLEAR_ON_READ_EN.
- Defined: in the cycle bin b's data returns, the block drives histo_wr_en_o=1, histo_wr_addr_o=b, histo_wr_data_o=0. This zeroes the histogram for the next frame. The write port is separate from the read port, so reads and writes never collide.
- Undefined: histo_wr_en_o, histo_wr_addr_o and histo_wr_data_o are tied to 0, and the SRAM contents are untouched.

Test Plan:
- Uniform histogram, 4 per bin, N=1024, start -> th_vld_o at cycle 258, thresholds = 31,63,95,127,159,191,223.
- All 512 pixels in bin 100, N=512 -> all seven thresholds = 100. With N=512 also confirm target_7 = (7*512)>>3 = 448.
- Empty histogram, N=0 -> all thresholds = 0. Empty histogram, N=64 -> all thresholds = 255 (never reached).
- Second start_i pulse in cycle 50 of a run -> ignored: exactly one th_vld_o at cycle 258, result from the first N. A fresh start after IDLE is then accepted.
- rst_n asserted in cycle 120 -> busy_o, histo_rd_en_o and th_vld_o drop immediately. th_o=0 and no th_vld_o follows. The next start runs the full 258-cycle sequence.
- With HISTO_CLEAR_ON_READ_EN: after a run every SRAM bin reads 0, with writes to addresses 0..255 in cycles 2..257. Without the macro: SRAM contents are unchanged and histo_wr_en_o stays 0 throughout.

Source files
------------

// File: rtl/histo_th_calc.sv
// Histogram threshold calculator: streams the 256-bin histogram SRAM, accumulates the cumulative
// pixel count and captures the equal-population quantization thresholds. Define HISTO_CLEAR_ON_READ_EN
// to zero every bin in the SRAM as its data returns.
module histo_th_calc #(
    parameter int P_DEPTH_BIT      = 8,
    parameter int P_DEPTH_SIZE_BIT = 10,
    parameter int P_DEPTH_QNT_BIT  = 3,
    parameter int P_TH_NUM         = 7
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic [P_DEPTH_SIZE_BIT:0]       pix_num_i,
    output logic                            busy_o,
    output logic                            histo_rd_en_o,
    output logic [P_DEPTH_BIT-1:0]          histo_rd_addr_o,
    input  logic [P_DEPTH_SIZE_BIT-1:0]     histo_rd_data_i,
    output logic                            histo_wr_en_o,
    output logic [P_DEPTH_BIT-1:0]          histo_wr_addr_o,
    output logic [P_DEPTH_SIZE_BIT-1:0]     histo_wr_data_o,
    output logic [P_TH_NUM*P_DEPTH_BIT-1:0] th_o,
    output logic                            th_vld_o
);

    localparam int N_W    = P_DEPTH_SIZE_BIT + 1;
    localparam int CUM_W  = P_DEPTH_SIZE_BIT + 2;
    localparam int PROD_W = N_W + P_DEPTH_QNT_BIT;
    localparam logic [P_DEPTH_BIT-1:0] LAST_BIN = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                               state_q;
    logic                                 busy_q;
    logic                                 rd_en_q;
    logic [P_DEPTH_BIT-1:0]               rd_addr_q;
    logic                                 rd_vld_q;
    logic [P_DEPTH_BIT-1:0]               rd_bin_q;
    logic [N_W-1:0]                       n_q;
    logic [CUM_W-1:0]                     cum_q, cum_d;
    logic [CUM_W:0]                       cum_sum;
    logic [P_TH_NUM-1:0][P_DEPTH_BIT-1:0] th_w_q, th_w_d;
    logic [P_TH_NUM-1:0]                  found_q, found_d;
    logic [P_TH_NUM*P_DEPTH_BIT-1:0]      th_q;
    logic                                 th_vld_q;
    logic [P_TH_NUM-1:0][CUM_W-1:0]       target;

    // target_k = (k*N) >> P_DEPTH_QNT_BIT; the product never exceeds PROD_W bits.
    always_comb begin
        for (int k = 1; k <= P_TH_NUM; k++) begin
            target[k-1] = CUM_W'((PROD_W'(k) * PROD_W'(n_q)) >> P_DEPTH_QNT_BIT);
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cum_d   = cum_q;
        th_w_d  = th_w_q;
        found_d = found_q;
        cum_sum = {1'b0, cum_q} + (CUM_W+1)'(histo_rd_data_i);
        if (rd_vld_q) begin
            // Saturate rather than wrap so an over-full histogram cannot fake an early crossing.
            cum_d = cum_sum[CUM_W] ? '1 : cum_sum[CUM_W-1:0];
            for (int k = 0; k < P_TH_NUM; k++) begin
                if (!found_q[k] && (cum_d >= target[k])) begin
                    th_w_d[k]  = rd_bin_q;
                    found_d[k] = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_bin_q  <= '0;
            n_q       <= '0;
            cum_q     <= '0;
            th_w_q    <= '0;
            found_q   <= '0;
            th_q      <= '0;
            th_vld_q  <= 1'b0;
        end else begin
            // SRAM data returns one cycle after the read is issued.
            rd_vld_q <= rd_en_q;
            rd_bin_q <= rd_addr_q;
            cum_q    <= cum_d;
            th_w_q   <= th_w_d;
            found_q  <= found_d;
            th_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q   <= S_READ;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        n_q       <= pix_num_i;
                        cum_q     <= '0;
                        th_w_q    <= {P_TH_NUM{LAST_BIN}};
                        found_q   <= '0;
                    end
                end
                S_READ: begin
                    if (rd_addr_q == LAST_BIN) begin
                        state_q <= S_DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The last bin is folded in on this edge, so publish the next-state thresholds.
                    state_q  <= S_DONE;
                    th_q     <= th_w_d;
                    th_vld_q <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign histo_rd_en_o   = rd_en_q;
    assign histo_rd_addr_o = rd_addr_q;
    assign th_o            = th_q;
    assign th_vld_o        = th_vld_q;

`ifdef HISTO_CLEAR_ON_READ_EN
    assign histo_wr_en_o   = rd_vld_q;
    assign histo_wr_addr_o = rd_bin_q;
    assign histo_wr_data_o = '0;
`else
    assign histo_wr_en_o   = 1'b0;
    assign histo_wr_addr_o = '0;
    assign histo_wr_data_o = '0;
`endif

endmodule
